// File: rtl/universal_shift_register_if.sv
// Control, data and status bundle for universal_shift_register.
// The register side uses the slave modport and the controlling side uses master.
interface universal_shift_register_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH);

  logic             en;
  logic [2:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic [CNT_W-1:0] shift_cnt;
  logic             word_valid;

  modport master (
    output en, mode, sin_r, sin_l, pin,
    input  q, sout_r, sout_l, shift_cnt, word_valid
  );

  modport slave (
    input  en, mode, sin_r, sin_l, pin,
    output q, sout_r, sout_l, shift_cnt, word_valid
  );
endinterface

// File: rtl/universal_shift_register.sv
// N-bit universal shift register: shift, rotate, load and clear, with a serial-shift
// counter that strobes word_valid in the cycle in which a complete serial word sits in q.
module universal_shift_register #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  universal_shift_register_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_ROR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             word_valid_reg;
  logic             word_valid_next;
  logic             serial_shift;

  logic [WIDTH-1:0] shr_vec;
  logic [WIDTH-1:0] shl_vec;
  logic [WIDTH-1:0] ror_vec;
  logic [WIDTH-1:0] rol_vec;

  // Per-bit candidate next values for the four serial movements.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bits
      if (gi == WIDTH - 1) begin : g_msb
        assign shr_vec[gi] = bus.sin_r;
        assign ror_vec[gi] = q_reg[0];
      end else begin : g_upper
        assign shr_vec[gi] = q_reg[gi+1];
        assign ror_vec[gi] = q_reg[gi+1];
      end
      if (gi == 0) begin : g_lsb
        assign shl_vec[gi] = bus.sin_l;
        assign rol_vec[gi] = q_reg[WIDTH-1];
      end else begin : g_lower
        assign shl_vec[gi] = q_reg[gi-1];
        assign rol_vec[gi] = q_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    q_next          = q_reg;
    cnt_next        = cnt_reg;
    word_valid_next = 1'b0;
    serial_shift    = 1'b0;
    case (bus.mode)
      MODE_HOLD: q_next = q_reg;
      MODE_SHR: begin
        q_next       = shr_vec;
        serial_shift = 1'b1;
      end
      MODE_SHL: begin
        q_next       = shl_vec;
        serial_shift = 1'b1;
      end
      MODE_ROR: q_next = ror_vec;
      MODE_ROL: q_next = rol_vec;
      MODE_LOAD: begin
        q_next   = bus.pin;
        cnt_next = '0;
      end
      MODE_CLR: begin
        q_next   = '0;
        cnt_next = '0;
      end
      default: q_next = q_reg;
    endcase
    // Left and right shifts share one counter, so mixed-direction words still complete.
    if (serial_shift) begin
      if (cnt_reg == CNT_MAX) begin
        cnt_next        = '0;
        word_valid_next = 1'b1;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg          <= '0;
      cnt_reg        <= '0;
      word_valid_reg <= 1'b0;
    end else if (bus.en) begin
      q_reg          <= q_next;
      cnt_reg        <= cnt_next;
      word_valid_reg <= word_valid_next;
    end else begin
      word_valid_reg <= 1'b0;
    end
  end

  assign bus.q          = q_reg;
  assign bus.sout_r     = q_reg[0];
  assign bus.sout_l     = q_reg[WIDTH-1];
  assign bus.shift_cnt  = cnt_reg;
  assign bus.word_valid = word_valid_reg;
endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench for universal_shift_register at WIDTH=4 and WIDTH=8: stimulus queues
// hand-computed expectations per edge, a monitor pops and compares them on the falling edge.
module tb_universal_shift_register;
  typedef struct {
    logic [7:0] q;
    logic [2:0] cnt;
    logic       wv;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst4;
  logic rst8;
  int   checks = 0;
  int   errors = 0;
  exp_t sb4[$];
  exp_t sb8[$];

  always #5 clk = ~clk;

  universal_shift_register_if #(.WIDTH(4)) bus4 ();
  universal_shift_register_if #(.WIDTH(8)) bus8 ();

  universal_shift_register #(.WIDTH(4)) dut4 (.clk(clk), .reset(rst4), .bus(bus4));
  universal_shift_register #(.WIDTH(8)) dut8 (.clk(clk), .reset(rst8), .bus(bus8));

  task automatic step4(input logic r, input logic e, input logic [2:0] m, input logic sr,
                       input logic sl, input logic [3:0] p, input logic [3:0] eq,
                       input logic [1:0] ec, input logic ew, input string name);
    exp_t x;
    rst4 = r; bus4.en = e; bus4.mode = m; bus4.sin_r = sr; bus4.sin_l = sl; bus4.pin = p;
    @(posedge clk);
    #1;
    x.q = {4'h0, eq}; x.cnt = {1'b0, ec}; x.wv = ew; x.name = name;
    sb4.push_back(x);
  endtask

  task automatic step8(input logic r, input logic e, input logic [2:0] m, input logic sr,
                       input logic sl, input logic [7:0] p, input logic [7:0] eq,
                       input logic [2:0] ec, input logic ew, input string name);
    exp_t x;
    rst8 = r; bus8.en = e; bus8.mode = m; bus8.sin_r = sr; bus8.sin_l = sl; bus8.pin = p;
    @(posedge clk);
    #1;
    x.q = eq; x.cnt = ec; x.wv = ew; x.name = name;
    sb8.push_back(x);
  endtask

  // Monitor: one comparison per queued transaction, serial outputs derived from expected q.
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] aq;
    logic [2:0] ac;
    if (sb4.size() > 0) begin
      e = sb4.pop_front();
      aq = {4'h0, bus4.q};
      ac = {1'b0, bus4.shift_cnt};
      checks++;
      if (aq !== e.q || ac !== e.cnt || bus4.word_valid !== e.wv ||
          bus4.sout_r !== e.q[0] || bus4.sout_l !== e.q[3]) begin
        errors++;
        $display("FAIL w4 %s: got q=%h cnt=%0d wv=%b sr=%b sl=%b, want q=%h cnt=%0d wv=%b sr=%b sl=%b",
                 e.name, aq, ac, bus4.word_valid, bus4.sout_r, bus4.sout_l,
                 e.q, e.cnt, e.wv, e.q[0], e.q[3]);
      end else begin
        $display("ok   w4 %s: q=%h cnt=%0d wv=%b", e.name, aq, ac, bus4.word_valid);
      end
    end
    if (sb8.size() > 0) begin
      e = sb8.pop_front();
      aq = bus8.q;
      ac = bus8.shift_cnt;
      checks++;
      if (aq !== e.q || ac !== e.cnt || bus8.word_valid !== e.wv ||
          bus8.sout_r !== e.q[0] || bus8.sout_l !== e.q[7]) begin
        errors++;
        $display("FAIL w8 %s: got q=%h cnt=%0d wv=%b sr=%b sl=%b, want q=%h cnt=%0d wv=%b sr=%b sl=%b",
                 e.name, aq, ac, bus8.word_valid, bus8.sout_r, bus8.sout_l,
                 e.q, e.cnt, e.wv, e.q[0], e.q[7]);
      end else begin
        $display("ok   w8 %s: q=%h cnt=%0d wv=%b", e.name, aq, ac, bus8.word_valid);
      end
    end
  end

  initial begin
    logic [7:0] v;
    rst4 = 1'b1; bus4.en = 1'b0; bus4.mode = 3'b000; bus4.sin_r = 1'b0; bus4.sin_l = 1'b0; bus4.pin = '0;
    rst8 = 1'b1; bus8.en = 1'b0; bus8.mode = 3'b000; bus8.sin_r = 1'b0; bus8.sin_l = 1'b0; bus8.pin = '0;
    @(negedge clk);

    // Serial-in right shift fills a 4-bit word.
    step4(1, 0, 3'b000, 0, 0, 4'h0, 4'b0000, 0, 0, "reset");
    step4(0, 1, 3'b001, 1, 0, 4'h0, 4'b1000, 1, 0, "shr1");
    step4(0, 1, 3'b001, 0, 0, 4'h0, 4'b0100, 2, 0, "shr2");
    step4(0, 1, 3'b001, 1, 0, 4'h0, 4'b1010, 3, 0, "shr3");
    step4(0, 1, 3'b001, 1, 0, 4'h0, 4'b1101, 0, 1, "shr4_word");
    step4(0, 1, 3'b000, 0, 0, 4'h0, 4'b1101, 0, 0, "hold_drops_wv");

    // Reset mid-word discards the partial count.
    step4(0, 1, 3'b001, 0, 0, 4'h0, 4'b0110, 1, 0, "mid_shr1");
    step4(0, 1, 3'b001, 0, 0, 4'h0, 4'b0011, 2, 0, "mid_shr2");
    step4(1, 1, 3'b001, 1, 0, 4'h0, 4'b0000, 0, 0, "mid_reset");
    step4(0, 1, 3'b001, 1, 0, 4'h0, 4'b1000, 1, 0, "post_rst1");
    step4(0, 1, 3'b001, 1, 0, 4'h0, 4'b1100, 2, 0, "post_rst2");
    step4(0, 1, 3'b001, 1, 0, 4'h0, 4'b1110, 3, 0, "post_rst3");
    step4(0, 1, 3'b001, 1, 0, 4'h0, 4'b1111, 0, 1, "post_rst4_word");

    // Clock enable freezes q and the counter.
    step4(0, 1, 3'b001, 0, 0, 4'h0, 4'b0111, 1, 0, "en1_a");
    step4(0, 0, 3'b001, 0, 0, 4'h0, 4'b0111, 1, 0, "en0_a");
    step4(0, 1, 3'b001, 0, 0, 4'h0, 4'b0011, 2, 0, "en1_b");
    step4(0, 0, 3'b001, 0, 0, 4'h0, 4'b0011, 2, 0, "en0_b");
    step4(0, 1, 3'b001, 0, 0, 4'h0, 4'b0001, 3, 0, "en1_c");
    step4(0, 1, 3'b001, 0, 0, 4'h0, 4'b0000, 0, 1, "en1_word");

    // Load, clear and reserved mode.
    step4(0, 1, 3'b001, 1, 0, 4'h0, 4'b1000, 1, 0, "pre_ld1");
    step4(0, 1, 3'b001, 1, 0, 4'h0, 4'b1100, 2, 0, "pre_ld2");
    step4(0, 1, 3'b001, 1, 0, 4'h0, 4'b1110, 3, 0, "pre_ld3");
    step4(0, 1, 3'b101, 0, 0, 4'b0110, 4'b0110, 0, 0, "load");
    step4(0, 1, 3'b110, 0, 0, 4'h0, 4'b0000, 0, 0, "clear");
    step4(0, 1, 3'b111, 1, 1, 4'hF, 4'b0000, 0, 0, "rsv_a");
    step4(0, 1, 3'b101, 0, 0, 4'b0110, 4'b0110, 0, 0, "reload");
    step4(0, 1, 3'b010, 0, 1, 4'h0, 4'b1101, 1, 0, "shl_a");
    step4(0, 1, 3'b111, 0, 0, 4'h0, 4'b1101, 1, 0, "rsv_b1");
    step4(0, 1, 3'b111, 1, 1, 4'h0, 4'b1101, 1, 0, "rsv_b2");
    step4(0, 1, 3'b111, 0, 0, 4'hF, 4'b1101, 1, 0, "rsv_b3");

    // Mixed directions count toward one word; then rotate and gated load.
    step4(0, 1, 3'b001, 0, 0, 4'h0, 4'b0110, 2, 0, "mix_shr");
    step4(0, 1, 3'b010, 0, 0, 4'h0, 4'b1100, 3, 0, "mix_shl0");
    step4(0, 1, 3'b010, 0, 1, 4'h0, 4'b1001, 0, 1, "mix_shl1_word");
    step4(0, 1, 3'b011, 0, 0, 4'h0, 4'b1100, 0, 0, "ror4");
    step4(0, 0, 3'b101, 0, 0, 4'hF, 4'b1100, 0, 0, "load_gated");

    // WIDTH=8 operations from 0xA5.
    step8(1, 0, 3'b000, 0, 0, 8'h00, 8'h00, 0, 0, "reset");
    step8(0, 1, 3'b101, 0, 0, 8'hA5, 8'hA5, 0, 0, "load_a5");
    step8(0, 1, 3'b010, 0, 0, 8'h00, 8'h4A, 1, 0, "shl0");
    step8(0, 1, 3'b101, 0, 0, 8'hA5, 8'hA5, 0, 0, "load_a5");
    step8(0, 1, 3'b011, 0, 0, 8'h00, 8'hD2, 0, 0, "ror");
    step8(0, 1, 3'b101, 0, 0, 8'hA5, 8'hA5, 0, 0, "load_a5");
    step8(0, 1, 3'b100, 0, 0, 8'h00, 8'h4B, 0, 0, "rol");
    step8(0, 1, 3'b101, 0, 0, 8'hA5, 8'hA5, 0, 0, "load_a5");
    step8(0, 1, 3'b001, 1, 0, 8'h00, 8'hD2, 1, 0, "shr1");
    step8(0, 1, 3'b011, 0, 0, 8'h00, 8'h69, 1, 0, "ror_keeps_cnt");
    step8(0, 1, 3'b100, 0, 0, 8'h00, 8'hD2, 1, 0, "rol_keeps_cnt");

    // 24 continuous right shifts of ones: word strobes at 8, 16 and 24.
    step8(1, 0, 3'b000, 0, 0, 8'h00, 8'h00, 0, 0, "reset2");
    for (int k = 1; k <= 24; k++) begin
      v = 8'hFF;
      if (k < 8) v = v << (8 - k);
      step8(0, 1, 3'b001, 1, 0, 8'h00, v, 3'(k % 8), (k % 8) == 0, $sformatf("cont%0d", k));
    end
    step8(0, 1, 3'b000, 0, 0, 8'h00, 8'hFF, 0, 0, "cont_hold");

    repeat (3) @(posedge clk);
    checks++;
    if (sb4.size() != 0 || sb8.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", sb4.size(), sb8.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
